// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to 4-digit BCD converter
//
// Purpose: converts an IN_W-bit unsigned value into four BCD digits using
// one double-dabble step per clock. A start in IDLE captures bin; the FSM
// then spends IN_W cycles in SHIFT and one cycle in DONE, where the digit
// outputs and ovf update together with a one-cycle done pulse.
//
// Ports:
//   clk              single clock, rising edge
//   rst_n            synchronous active-low reset
//   start            conversion request, sampled only in IDLE
//   bin[IN_W-1:0]    unsigned binary input, captured on the accepting edge
//   busy             high while in SHIFT
//   done             one-cycle pulse when the digit outputs update
//   bcd3..bcd0       thousands, hundreds, tens, units digits
//   ovf              last captured bin was above 9999
//
// Configuration macro: BIN2BCD_CLAMP_EN - when defined, an out-of-range
// input reports 9,9,9,9; otherwise the digits are bin mod 10000.

module bin2bcd_seq #(
  parameter int IN_W = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic [3:0]      bcd3,
  output logic [3:0]      bcd2,
  output logic [3:0]      bcd1,
  output logic [3:0]      bcd0,
  output logic            ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] LAST = 4'(IN_W - 1);

  state_t          state;
  logic [IN_W-1:0] bin_shift;
  logic [15:0]     scratch;
  logic [15:0]     scratch_nxt;
  logic [3:0]      cnt;
  logic            ovf_next;
  logic            ovf_cap;
  logic [2:0]      th_adj;
  logic [11:0]     low_adj;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  assign ovf_cap = (32'(bin) > 32'd9999);

  // Only the low three bits of the adjusted thousands nibble survive the
  // shift; the bit that falls off is the ten-thousands carry, which is what
  // makes the 16-bit scratch hold the value modulo 10000.
  always_comb begin
    low_adj     = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
    th_adj      = (scratch[15:12] >= 4'd5) ? 3'(scratch[15:12] + 4'd3) : scratch[14:12];
    scratch_nxt = {th_adj, low_adj, bin_shift[IN_W-1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd3      <= 4'd0;
      bcd2      <= 4'd0;
      bcd1      <= 4'd0;
      bcd0      <= 4'd0;
      ovf       <= 1'b0;
      cnt       <= 4'd0;
      scratch   <= 16'd0;
      bin_shift <= '0;
      ovf_next  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bin_shift <= bin;
            scratch   <= 16'd0;
            cnt       <= 4'd0;
            ovf_next  <= ovf_cap;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          scratch   <= scratch_nxt;
          bin_shift <= bin_shift << 1;
          if (cnt == LAST) begin
            // Final step: publish straight from the combinational result so
            // the digits are valid in the same cycle done is high.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            ovf   <= ovf_next;
`ifdef BIN2BCD_CLAMP_EN
            if (ovf_next) begin
              {bcd3, bcd2, bcd1, bcd0} <= 16'h9999;
            end else begin
              {bcd3, bcd2, bcd1, bcd0} <= scratch_nxt;
            end
`else
            {bcd3, bcd2, bcd1, bcd0} <= scratch_nxt;
`endif
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

  localparam int IN_W = 14;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [IN_W-1:0] bin;
  logic            busy;
  logic            done;
  logic [3:0]      bcd3, bcd2, bcd1, bcd0;
  logic            ovf;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.IN_W(IN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: counts cycles since the accepting edge and produces
  // the decimal result with plain arithmetic.
  int phase = 0;
  int cap   = 0;
  int m_val = 0;
  logic m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;

  function automatic int expect_val(input int v);
    if (v > 9999) begin
`ifdef BIN2BCD_CLAMP_EN
      return 9999;
`else
      return v % 10000;
`endif
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      phase = 0; m_busy = 1'b0; m_done = 1'b0; m_val = 0; m_ovf = 1'b0;
    end else if (phase == 0) begin
      m_done = 1'b0;
      if (start) begin
        cap = int'(bin); phase = 1; m_busy = 1'b1;
      end
    end else if (phase < IN_W) begin
      phase = phase + 1;
    end else if (phase == IN_W) begin
      m_busy = 1'b0; m_done = 1'b1;
      m_val  = expect_val(cap);
      m_ovf  = (cap > 9999);
      phase  = IN_W + 1;
    end else begin
      m_done = 1'b0; phase = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_val();
    return int'(bcd3) * 1000 + int'(bcd2) * 100 + int'(bcd1) * 10 + int'(bcd0);
  endfunction

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("ovf", int'(ovf), int'(m_ovf));
      chk("digits", dut_val(), m_val);
      chk("digit_range", int'(bcd3 <= 9 && bcd2 <= 9 && bcd1 <= 9 && bcd0 <= 9), 1);
    end
  end

  int last_lat;

  // Issue one request; returns after the done cycle, leaving the DUT in DONE.
  task automatic convert(input int v);
    int n;
    @(negedge clk);
    bin   = IN_W'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin   = IN_W'($urandom);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    last_lat = n;
    if (!done) chk("done_timeout", 0, 1);
  endtask

  int dcount;
  int bounds[$] = '{9990, 9998, 9999, 10000, 10001, 16382, 16383, 1, 9, 10, 99, 100, 999, 1000};

  initial begin
    rst_n = 1'b0; start = 1'b1; bin = IN_W'(1234);
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_digits", dut_val(), 0);
    rst_n = 1'b1; start = 1'b0;

    // 1234: latency and digits pinned by hand
    convert(1234);
    chk("lat_1234", last_lat, 15);
    chk("dig_1234", dut_val(), 1234);
    chk("ovf_1234", int'(ovf), 0);
    @(negedge clk);
    chk("hold_1234", dut_val(), 1234);
    chk("done_one_cycle", int'(done), 0);

    // back-to-back 0 then 9999
    convert(0);
    chk("dig_0", dut_val(), 0);
    convert(9999);
    chk("dig_9999", dut_val(), 9999);
    chk("lat_9999", last_lat, 15);

    // out of range
    convert(12345);
    chk("ovf_12345", int'(ovf), 1);
`ifdef BIN2BCD_CLAMP_EN
    chk("dig_12345", dut_val(), 9999);
`else
    chk("dig_12345", dut_val(), 2345);
`endif

    // start held high: one conversion every 16 cycles
    @(negedge clk);
    @(negedge clk);
    bin = IN_W'(777); start = 1'b1;
    dcount = 0;
    repeat (64) begin
      @(negedge clk);
      if (done) dcount++;
    end
    start = 1'b0;
    chk("held_start_dones", dcount, 4);
    repeat (20) @(negedge clk);

    // reset at cycle 7 of a 4321 conversion
    bin = IN_W'(4321); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_digits", dut_val(), 0);
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    convert(4321);
    chk("dig_4321", dut_val(), 4321);

    foreach (bounds[i]) convert(bounds[i]);
    for (int v = 0; v < 16384; v += 11) convert(v);

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
